// File: rtl/lcd_spi_pkg.sv
// Shared definitions for the LCD SPI receiver: command codes, decoder
// state encoding, coordinate width and the window span helper.
package lcd_spi_pkg;

  localparam int COORD_W = 9;

  localparam logic [7:0] CMD_CASET = 8'h2A;
  localparam logic [7:0] CMD_RASET = 8'h2B;
  localparam logic [7:0] CMD_RAMWR = 8'h2C;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CASET = 2'd1,
    ST_RASET = 2'd2,
    ST_RAMWR = 2'd3
  } dec_state_e;

  // Number of coordinates covered by [s, e]; an inverted window spans nothing.
  function automatic logic [COORD_W:0] win_span(input logic [COORD_W-1:0] s,
                                                input logic [COORD_W-1:0] e);
    if (e < s) return '0;
    return {1'b0, e} - {1'b0, s} + (COORD_W+1)'(1);
  endfunction

endpackage

// File: rtl/lcd_spi_rx_if.sv
// 4-wire LCD SPI bus bundle.
//   lcd_cs   : chip select, active low
//   lcd_dc   : 0 = command, 1 = data
//   lcd_sclk : SPI clock, idle low
//   lcd_mosi : serial data, MSB first
// master drives the bus, slave observes it.
interface lcd_spi_rx_if;
  logic lcd_cs;
  logic lcd_dc;
  logic lcd_sclk;
  logic lcd_mosi;

  modport master (output lcd_cs, output lcd_dc, output lcd_sclk, output lcd_mosi);
  modport slave  (input  lcd_cs, input  lcd_dc, input  lcd_sclk, input  lcd_mosi);
endinterface

// File: rtl/spi_word_rx.sv
// Bit-level receiver: synchronizes the SPI bus into the 50 MHz domain,
// detects sclk/cs rising edges and assembles 9-bit {dc, byte} words.
// Ports:
//   sys_clk_50MHz, sys_rst_n : clock, async active-low reset
//   bus                      : LCD SPI bus (slave modport)
//   word_valid_o             : one-cycle pulse, word_data_o is new
//   word_data_o              : {dc, byte}
//   frame_err_o              : one-cycle pulse, cs rose mid-byte
module spi_word_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic         sys_clk_50MHz,
  input  logic         sys_rst_n,
  lcd_spi_rx_if.slave  bus,
  output logic         word_valid_o,
  output logic [8:0]   word_data_o,
  output logic         frame_err_o
);

  logic [SYNC_STAGES-1:0] cs_sync_q, dc_sync_q, sclk_sync_q, mosi_sync_q;
  logic sclk_prev_q, cs_prev_q;
  logic sclk_rise_q, cs_rise_q;
  logic cs_q, dc_q, mosi_q;
  logic armed_q;
  logic [7:0] shift_q;
  logic [2:0] bit_cnt_q;
  logic shift_en, word_done;

  // The cs-rise cycle still accepts a coincident sclk edge so that a word
  // completing together with cs release is delivered rather than dropped.
  // armed_q blocks reception after reset until cs has been seen high.
  assign shift_en  = sclk_rise_q & armed_q & (~cs_q | cs_rise_q);
  assign word_done = shift_en & (bit_cnt_q == 3'd7);

  always_ff @(posedge sys_clk_50MHz or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      // cs chain resets low so a genuine high has to propagate before arming.
      cs_sync_q    <= '0;
      dc_sync_q    <= '0;
      sclk_sync_q  <= '0;
      mosi_sync_q  <= '0;
      sclk_prev_q  <= 1'b0;
      cs_prev_q    <= 1'b0;
      sclk_rise_q  <= 1'b0;
      cs_rise_q    <= 1'b0;
      cs_q         <= 1'b0;
      dc_q         <= 1'b0;
      mosi_q       <= 1'b0;
      armed_q      <= 1'b0;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      word_valid_o <= 1'b0;
      word_data_o  <= '0;
      frame_err_o  <= 1'b0;
    end else begin
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0],   bus.lcd_cs};
      dc_sync_q   <= {dc_sync_q[SYNC_STAGES-2:0],   bus.lcd_dc};
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], bus.lcd_sclk};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.lcd_mosi};

      // Registered edge detect; data/dc/cs are delayed by the same stage.
      sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
      sclk_rise_q <= sclk_sync_q[SYNC_STAGES-1] & ~sclk_prev_q;
      cs_prev_q   <= cs_sync_q[SYNC_STAGES-1];
      cs_rise_q   <= cs_sync_q[SYNC_STAGES-1] & ~cs_prev_q;
      cs_q        <= cs_sync_q[SYNC_STAGES-1];
      dc_q        <= dc_sync_q[SYNC_STAGES-1];
      mosi_q      <= mosi_sync_q[SYNC_STAGES-1];

      if (cs_q) armed_q <= 1'b1;

      word_valid_o <= word_done;
      frame_err_o  <= cs_rise_q & ~word_done & (bit_cnt_q != 3'd0);

      if (word_done) begin
        word_data_o <= {dc_q, shift_q[6:0], mosi_q};
        bit_cnt_q   <= '0;
      end else if (cs_rise_q) begin
        bit_cnt_q   <= '0;
      end else if (shift_en) begin
        shift_q     <= {shift_q[6:0], mosi_q};
        bit_cnt_q   <= bit_cnt_q + 3'd1;
      end
    end
  end

endmodule

// File: rtl/lcd_spi_rx.sv
// LCD-side SPI receiver: reassembles {dc, byte} words and decodes CASET,
// RASET and RAMWR to track the active window and the received pixel count.
// Ports:
//   sys_clk_50MHz, sys_rst_n     : clock, async active-low reset
//   bus                          : LCD SPI bus (slave modport)
//   word_valid, word_data        : received word strobe and {dc, byte}
//   x_start/x_end, y_start/y_end : column / row window
//   pixel_cnt                    : RGB565 pixels since the last RAMWR
//   frame_done                   : pulse when pixel_cnt reaches window area
//   frame_err                    : pulse when cs rose mid-byte
module lcd_spi_rx
  import lcd_spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int PIX_W       = 17
) (
  input  logic               sys_clk_50MHz,
  input  logic               sys_rst_n,
  lcd_spi_rx_if.slave        bus,
  output logic               word_valid,
  output logic [8:0]         word_data,
  output logic [COORD_W-1:0] x_start,
  output logic [COORD_W-1:0] x_end,
  output logic [COORD_W-1:0] y_start,
  output logic [COORD_W-1:0] y_end,
  output logic [PIX_W-1:0]   pixel_cnt,
  output logic               frame_done,
  output logic               frame_err
);

  dec_state_e         state_q;
  logic [1:0]         param_idx_q;
  logic               phase_q;
  logic [COORD_W-1:0] x_start_q, x_end_q, y_start_q, y_end_q;
  logic [PIX_W-1:0]   pixel_cnt_q;
  logic               frame_done_q;
  logic [PIX_W-1:0]   area_d;
  logic [PIX_W-1:0]   pix_inc_d;

  spi_word_rx #(.SYNC_STAGES(SYNC_STAGES)) u_word_rx (
    .sys_clk_50MHz (sys_clk_50MHz),
    .sys_rst_n     (sys_rst_n),
    .bus           (bus),
    .word_valid_o  (word_valid),
    .word_data_o   (word_data),
    .frame_err_o   (frame_err)
  );

  assign area_d    = PIX_W'(win_span(x_start_q, x_end_q)) * PIX_W'(win_span(y_start_q, y_end_q));
  assign pix_inc_d = pixel_cnt_q + PIX_W'(1);

  always_ff @(posedge sys_clk_50MHz or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q      <= ST_IDLE;
      param_idx_q  <= '0;
      phase_q      <= 1'b0;
      x_start_q    <= '0;
      x_end_q      <= '0;
      y_start_q    <= '0;
      y_end_q      <= '0;
      pixel_cnt_q  <= '0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      if (word_valid) begin
        if (!word_data[8]) begin
          param_idx_q <= '0;
          case (word_data[7:0])
            CMD_CASET: state_q <= ST_CASET;
            CMD_RASET: state_q <= ST_RASET;
            CMD_RAMWR: begin
              state_q     <= ST_RAMWR;
              pixel_cnt_q <= '0;
              phase_q     <= 1'b0;
            end
            default:   state_q <= ST_IDLE;
          endcase
        end else begin
          case (state_q)
            ST_CASET: begin
              param_idx_q <= param_idx_q + 2'd1;
              case (param_idx_q)
                2'd0: x_start_q[8]   <= word_data[0];
                2'd1: x_start_q[7:0] <= word_data[7:0];
                2'd2: x_end_q[8]     <= word_data[0];
                default: begin
                  x_end_q[7:0] <= word_data[7:0];
                  state_q      <= ST_IDLE;
                end
              endcase
            end
            ST_RASET: begin
              param_idx_q <= param_idx_q + 2'd1;
              case (param_idx_q)
                2'd0: y_start_q[8]   <= word_data[0];
                2'd1: y_start_q[7:0] <= word_data[7:0];
                2'd2: y_end_q[8]     <= word_data[0];
                default: begin
                  y_end_q[7:0] <= word_data[7:0];
                  state_q      <= ST_IDLE;
                end
              endcase
            end
            ST_RAMWR: begin
              phase_q <= ~phase_q;
              // Second byte of a pixel; the counter saturates at all-ones.
              if (phase_q && (pixel_cnt_q != '1)) begin
                pixel_cnt_q <= pix_inc_d;
                // A zero area can never match since the incremented count is >= 1.
                if (pix_inc_d == area_d) frame_done_q <= 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign x_start    = x_start_q;
  assign x_end      = x_end_q;
  assign y_start    = y_start_q;
  assign y_end      = y_end_q;
  assign pixel_cnt  = pixel_cnt_q;
  assign frame_done = frame_done_q;

endmodule
